// File: rtl/mips_core_pkg.sv
// Shared core types and constants for the physical register file and its users.
package mips_core_pkg;

    localparam int unsigned NUM_PHYS_REGS = 64;

    typedef logic [$clog2(NUM_PHYS_REGS)-1:0] phys_tag_t;

    localparam phys_tag_t ZERO_PHYS_TAG = '0;

endpackage

// File: rtl/prf_read_port.sv
// One read port of the physical register file: optional same-cycle write
// forwarding, then tag-0 / unused-port gating.
module prf_read_port
    import mips_core_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned PW         = 6,
    parameter int unsigned NUM_WRITE  = 2,
    parameter int unsigned BYPASS     = 1
) (
    input  logic                          rd_en,
    input  logic [PW-1:0]                 rd_addr,
    input  logic [DATA_WIDTH-1:0]         store_data,
    input  logic                          store_ready,
    input  logic [NUM_WRITE-1:0]          wr_en,
    input  logic [NUM_WRITE*PW-1:0]       wr_addr,
    input  logic [NUM_WRITE*DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic                          rd_ready
);

    always_comb begin
        rd_data  = store_data;
        rd_ready = store_ready;
        // Ascending scan so the highest-index matching write port wins.
        if (BYPASS != 0) begin
            for (int unsigned w = 0; w < NUM_WRITE; w++) begin
                if (wr_en[w] && (wr_addr[w*PW +: PW] == rd_addr)) begin
                    rd_data  = wr_data[w*DATA_WIDTH +: DATA_WIDTH];
                    rd_ready = 1'b1;
                end
            end
        end
        if (!rd_en || (rd_addr == PW'(ZERO_PHYS_TAG))) begin
            rd_data  = '0;
            rd_ready = 1'b1;
        end
    end

endmodule

// File: rtl/phys_reg_file.sv
// Multi-ported physical register file with per-tag ready bits, an
// incrementally maintained ready count and a sticky write-conflict flag.
module phys_reg_file
    import mips_core_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_PHYS   = 64,
    parameter int unsigned NUM_READ   = 4,
    parameter int unsigned NUM_WRITE  = 2,
    parameter int unsigned BYPASS     = 1
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [NUM_READ-1:0]                      rd_en,
    input  logic [NUM_READ*$clog2(NUM_PHYS)-1:0]     rd_addr,
    output logic [NUM_READ*DATA_WIDTH-1:0]           rd_data,
    output logic [NUM_READ-1:0]                      rd_ready,
    input  logic [NUM_WRITE-1:0]                     wr_en,
    input  logic [NUM_WRITE*$clog2(NUM_PHYS)-1:0]    wr_addr,
    input  logic [NUM_WRITE*DATA_WIDTH-1:0]          wr_data,
    input  logic                                     alloc_en,
    input  logic [$clog2(NUM_PHYS)-1:0]              alloc_addr,
    input  logic                                     flush,
    output logic [$clog2(NUM_PHYS+1)-1:0]            ready_count,
    output logic                                     wr_conflict
);

    localparam int unsigned PW = $clog2(NUM_PHYS);
    localparam int unsigned CW = $clog2(NUM_PHYS+1);
    localparam logic [PW-1:0] ZTAG = PW'(ZERO_PHYS_TAG);

    logic [DATA_WIDTH-1:0] regs [NUM_PHYS];
    logic [NUM_PHYS-1:0]   ready;
    logic [NUM_PHYS-1:0]   ready_nxt;
    logic [NUM_WRITE-1:0]  wr_act;
    logic                  alloc_act;
    logic                  conflict_now;
    logic [CW-1:0]         set_cnt;
    logic [CW-1:0]         clr_cnt;

    always_comb begin
        wr_act       = '0;
        alloc_act    = alloc_en && (alloc_addr != ZTAG) && !flush;
        ready_nxt    = ready;
        conflict_now = 1'b0;
        for (int unsigned w = 0; w < NUM_WRITE; w++) begin
            wr_act[w] = wr_en[w] && (wr_addr[w*PW +: PW] != ZTAG) && !flush;
        end
        if (flush) begin
            ready_nxt = '1;
        end else begin
            for (int unsigned w = 0; w < NUM_WRITE; w++) begin
                if (wr_act[w]) ready_nxt[wr_addr[w*PW +: PW]] = 1'b1;
            end
            // Allocation is applied last so it overrides a same-tag writeback.
            if (alloc_act) ready_nxt[alloc_addr] = 1'b0;
        end
        for (int unsigned i = 0; i < NUM_WRITE; i++) begin
            for (int unsigned j = i + 1; j < NUM_WRITE; j++) begin
                if (wr_act[i] && wr_act[j] && (wr_addr[i*PW +: PW] == wr_addr[j*PW +: PW]))
                    conflict_now = 1'b1;
            end
            if (wr_act[i] && alloc_act && (wr_addr[i*PW +: PW] == alloc_addr))
                conflict_now = 1'b1;
        end
    end

    always_comb begin
        set_cnt = '0;
        clr_cnt = '0;
        for (int unsigned t = 0; t < NUM_PHYS; t++) begin
            set_cnt = set_cnt + CW'(ready_nxt[t] & ~ready[t]);
            clr_cnt = clr_cnt + CW'(ready[t] & ~ready_nxt[t]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned t = 0; t < NUM_PHYS; t++) regs[t] <= '0;
            ready       <= '1;
            ready_count <= CW'(NUM_PHYS);
            wr_conflict <= 1'b0;
        end else begin
            for (int unsigned w = 0; w < NUM_WRITE; w++) begin
                if (wr_act[w]) regs[wr_addr[w*PW +: PW]] <= wr_data[w*DATA_WIDTH +: DATA_WIDTH];
            end
            ready       <= ready_nxt;
            ready_count <= ready_count + set_cnt - clr_cnt;
            if (conflict_now) wr_conflict <= 1'b1;
        end
    end

    for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
        prf_read_port #(
            .DATA_WIDTH (DATA_WIDTH),
            .PW         (PW),
            .NUM_WRITE  (NUM_WRITE),
            .BYPASS     (BYPASS)
        ) u_rd (
            .rd_en       (rd_en[p]),
            .rd_addr     (rd_addr[p*PW +: PW]),
            .store_data  (regs[rd_addr[p*PW +: PW]]),
            .store_ready (ready[rd_addr[p*PW +: PW]]),
            .wr_en       (wr_en),
            .wr_addr     (wr_addr),
            .wr_data     (wr_data),
            .rd_data     (rd_data[p*DATA_WIDTH +: DATA_WIDTH]),
            .rd_ready    (rd_ready[p])
        );
    end

endmodule
